// File: rtl/mem_fill_sequencer_pkg.sv
// Shared types and block geometry for the memory fill sequencer.
package mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFILL  = 2'd1,
        DFILL  = 2'd2,
        DWRITE = 2'd3
    } seq_state_t;

    localparam int WORD_BYTES     = 2;
    localparam int BLOCK_WORDS    = 8;
    localparam int BLOCK_OFF_BITS = 4;

endpackage

// File: rtl/mem_fill_counter.sv
// Issue and receive word counters for one block fill.
module mem_fill_counter
    import mem_seq_pkg::*;
#(
    parameter int WORDS = BLOCK_WORDS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       issue_step,
    input  logic       recv_step,
    output logic [3:0] issue_cnt,
    output logic [2:0] recv_cnt,
    output logic       issue_done,
    output logic       last_word
);

    logic [3:0] issue_cnt_reg;
    logic [2:0] recv_cnt_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            issue_cnt_reg <= 4'd0;
            recv_cnt_reg  <= 3'd0;
        end else if (clear) begin
            issue_cnt_reg <= 4'd0;
            recv_cnt_reg  <= 3'd0;
        end else begin
            // Issue counter saturates at WORDS so mem_en stays low afterwards.
            if (issue_step && !issue_done)
                issue_cnt_reg <= issue_cnt_reg + 4'd1;
            if (recv_step)
                recv_cnt_reg <= recv_cnt_reg + 3'd1;
        end
    end

    assign issue_cnt  = issue_cnt_reg;
    assign recv_cnt   = recv_cnt_reg;
    assign issue_done = (issue_cnt_reg == 4'(WORDS));
    assign last_word  = (recv_cnt_reg == 3'(WORDS - 1));

endmodule

// File: rtl/mem_fill_sequencer.sv
// Arbitrates icache fills, dcache fills and dcache stores onto a single-port memory.
// Optional round-robin arbitration between caches: define MEM_SEQ_ROUND_ROBIN_EN.
module mem_fill_sequencer
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int WORDS  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              d_req,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              i_grant,
    output logic              d_grant,
    output logic [DATA_W-1:0] fill_data,
    output logic [2:0]        fill_word,
    output logic              fill_valid,
    output logic              i_done,
    output logic              d_done,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_en,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid
);

    seq_state_t        state_reg, state_next;
    logic [ADDR_W-1:0] base_reg, base_next;
    logic              clear, issue_step, recv_step;
    logic [3:0]        issue_cnt;
    logic [2:0]        recv_cnt;
    logic              issue_done, last_word;
    logic              i_win;

    mem_fill_counter #(
        .WORDS(WORDS)
    ) u_counter (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .issue_step(issue_step),
        .recv_step (recv_step),
        .issue_cnt (issue_cnt),
        .recv_cnt  (recv_cnt),
        .issue_done(issue_done),
        .last_word (last_word)
    );

`ifdef MEM_SEQ_ROUND_ROBIN_EN
    // 0 = icache served last, 1 = dcache served last.
    logic last_owner_reg;

    always_ff @(posedge clk) begin
        if (!rst)
            last_owner_reg <= 1'b0;
        else if (state_reg == IDLE && state_next != IDLE)
            last_owner_reg <= (state_next != IFILL);
    end

    always_comb begin
        i_win = i_req && !(d_req && !last_owner_reg);
    end
`else
    always_comb begin
        i_win = i_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= IDLE;
            base_reg  <= '0;
        end else begin
            state_reg <= state_next;
            base_reg  <= base_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        base_next   = base_reg;
        clear       = 1'b0;
        issue_step  = 1'b0;
        recv_step   = 1'b0;
        i_grant     = 1'b0;
        d_grant     = 1'b0;
        fill_data   = '0;
        fill_word   = 3'd0;
        fill_valid  = 1'b0;
        i_done      = 1'b0;
        d_done      = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        mem_en      = 1'b0;
        mem_wr      = 1'b0;

        case (state_reg)
            IDLE: begin
                clear = 1'b1;
                if (i_win) begin
                    state_next = IFILL;
                    base_next  = {i_addr[ADDR_W-1:BLOCK_OFF_BITS], {BLOCK_OFF_BITS{1'b0}}};
                end else if (d_req && !d_wr) begin
                    state_next = DFILL;
                    base_next  = {d_addr[ADDR_W-1:BLOCK_OFF_BITS], {BLOCK_OFF_BITS{1'b0}}};
                end else if (d_req && d_wr) begin
                    state_next = DWRITE;
                end
            end

            IFILL, DFILL: begin
                i_grant    = (state_reg == IFILL);
                d_grant    = (state_reg == DFILL);
                mem_en     = !issue_done;
                issue_step = !issue_done;
                mem_addr   = base_reg + (ADDR_W'(issue_cnt) << $clog2(WORD_BYTES));
                // Words come back strictly in order, so recv_cnt is the word index.
                if (mem_valid) begin
                    fill_valid = 1'b1;
                    fill_data  = mem_rdata;
                    fill_word  = recv_cnt;
                    recv_step  = 1'b1;
                    if (last_word) begin
                        i_done     = (state_reg == IFILL);
                        d_done     = (state_reg == DFILL);
                        state_next = IDLE;
                    end
                end
            end

            DWRITE: begin
                d_grant     = 1'b1;
                mem_en      = 1'b1;
                mem_wr      = 1'b1;
                mem_addr    = d_addr;
                mem_data_in = d_wdata;
                d_done      = 1'b1;
                state_next  = IDLE;
            end

            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_fill_sequencer.sv
// Scoreboard bench for mem_fill_sequencer with a 3-cycle pipelined memory model.
module tb_mem_fill_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req, d_req, d_wr;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_grant, d_grant, fill_valid, i_done, d_done, mem_en, mem_wr;
    logic [15:0] fill_data, mem_addr, mem_data_in;
    logic [2:0]  fill_word;
    logic [15:0] mem_rdata;
    bit          mem_valid;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int          kind;   // 0 icache fill, 1 dcache fill, 2 store
        int          word;
        logic [15:0] addr;
        logic [15:0] data;
        bit          done;
    } exp_t;

    exp_t        fill_q[$];
    logic [15:0] addr_q[$];

    always #5 clk = ~clk;

    mem_fill_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .d_req      (d_req),
        .d_wr       (d_wr),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .i_grant    (i_grant),
        .d_grant    (d_grant),
        .fill_data  (fill_data),
        .fill_word  (fill_word),
        .fill_valid (fill_valid),
        .i_done     (i_done),
        .d_done     (d_done),
        .mem_addr   (mem_addr),
        .mem_data_in(mem_data_in),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid)
    );

    // Memory model: unwritten words read as ~address; read data valid 3 cycles after issue.
    bit          written [0:32767];
    logic [15:0] wmem    [0:32767];
    bit          p0, p1;
    logic [15:0] d0, d1;

    always @(posedge clk) begin
        p0 <= mem_en && !mem_wr;
        d0 <= written[mem_addr[15:1]] ? wmem[mem_addr[15:1]] : ~mem_addr;
        p1 <= p0;
        d1 <= d0;
        mem_valid <= p1;
        mem_rdata <= p1 ? d1 : 16'h0000;
        if (mem_en && mem_wr) begin
            written[mem_addr[15:1]] <= 1'b1;
            wmem[mem_addr[15:1]]    <= mem_data_in;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT issues a read, returns a word or stores.
    always @(negedge clk) begin
        exp_t        e;
        logic [15:0] a;
        if (mem_en === 1'b1 && mem_wr === 1'b0) begin
            if (addr_q.size() == 0) chk("issue_unexpected", {48'h0, mem_addr}, 64'hFFFF_FFFF);
            else begin
                a = addr_q.pop_front();
                chk("issue_addr", {48'h0, mem_addr}, {48'h0, a});
            end
        end
        if (fill_valid === 1'b1) begin
            if (fill_q.size() == 0) chk("fill_unexpected", {61'h0, fill_word}, 64'hFFFF_FFFF);
            else begin
                e = fill_q.pop_front();
                chk("fill_word", {61'h0, fill_word}, 64'(e.word));
                chk("fill_data", {48'h0, fill_data}, {48'h0, e.data});
                chk("fill_grant", {62'h0, i_grant, d_grant}, (e.kind == 0) ? 64'd2 : 64'd1);
                chk("fill_done", {62'h0, i_done, d_done},
                    !e.done ? 64'd0 : ((e.kind == 0) ? 64'd2 : 64'd1));
                if (e.done)
                    $display("txn %s fill base=%h done", (e.kind == 0) ? "icache" : "dcache",
                             e.addr);
            end
        end else if (d_done === 1'b1 && mem_wr === 1'b1) begin
            if (fill_q.size() == 0) chk("store_unexpected", {48'h0, mem_addr}, 64'hFFFF_FFFF);
            else begin
                e = fill_q.pop_front();
                chk("store_kind", 64'(e.kind), 64'd2);
                chk("store_addr", {48'h0, mem_addr}, {48'h0, e.addr});
                chk("store_data", {48'h0, mem_data_in}, {48'h0, e.data});
                chk("store_ctl", {60'h0, mem_en, mem_wr, d_grant, i_grant}, 64'hE);
                $display("txn dcache store addr=%h data=%h", e.addr, e.data);
            end
        end else if (i_done === 1'b1 || d_done === 1'b1) begin
            chk("spurious_done", {62'h0, i_done, d_done}, 64'd0);
        end
    end

    task automatic push_fill(input int kind, input logic [15:0] addr, input logic [15:0] w0,
                             input int n_issue, input int n_words);
        logic [15:0] base;
        exp_t        e;
        base = {addr[15:4], 4'h0};
        for (int k = 0; k < n_issue; k++) addr_q.push_back(base + 16'(2 * k));
        for (int k = 0; k < n_words; k++) begin
            e.kind = kind;
            e.word = k;
            e.addr = base;
            e.data = (k == 0) ? w0 : ~(base + 16'(2 * k));
            e.done = (k == 7);
            fill_q.push_back(e);
        end
    endtask

    task automatic wait_done(input bit is_i, input string name);
        int n;
        n = 0;
        while (!(is_i ? (i_done === 1'b1) : (d_done === 1'b1)) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk({name, "_timeout"}, 64'd0, 64'd1);
    endtask

    initial begin
        exp_t e;
        bit   first_i;
        int   n;
        rst = 1'b0; i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        i_addr = 16'h0; d_addr = 16'h0; d_wdata = 16'h0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {6'h0, i_grant, d_grant, fill_data, fill_word, fill_valid, i_done,
            d_done, mem_addr, mem_data_in, mem_en, mem_wr}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_grants", {62'h0, i_grant, d_grant}, 64'd0);

        // Write-through store, then a dcache fill of the same block sees it.
        e.kind = 2; e.word = 0; e.addr = 16'h0040; e.data = 16'hBEEF; e.done = 1'b0;
        fill_q.push_back(e);
        d_req = 1'b1; d_wr = 1'b1; d_addr = 16'h0040; d_wdata = 16'hBEEF;
        wait_done(1'b0, "store");
        d_req = 1'b0; d_wr = 1'b0;
        @(negedge clk);
        chk("idle_after_store", {61'h0, d_grant, mem_en, mem_wr}, 64'd0);

        push_fill(1, 16'h0046, 16'hBEEF, 8, 8);
        d_req = 1'b1; d_addr = 16'h0046;
        wait_done(1'b0, "dfill_0040");
        d_req = 1'b0;
        @(negedge clk);

        // Icache fill of 0x1236: addresses 0x1230..0x123E, word 0 = ~0x1230 = 0xEDCF.
        push_fill(0, 16'h1236, 16'hEDCF, 8, 8);
        i_req = 1'b1; i_addr = 16'h1236;
        wait_done(1'b1, "ifill_1230");
        i_req = 1'b0;
        @(negedge clk);

        // Simultaneous requests; icache was served last.
`ifdef MEM_SEQ_ROUND_ROBIN_EN
        first_i = 1'b0;
        push_fill(1, 16'h2000, 16'hDFFF, 8, 8);
        push_fill(0, 16'h3008, 16'hCFFF, 8, 8);
`else
        first_i = 1'b1;
        push_fill(0, 16'h3008, 16'hCFFF, 8, 8);
        push_fill(1, 16'h2000, 16'hDFFF, 8, 8);
`endif
        i_req = 1'b1; i_addr = 16'h3008; d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h2000;
        wait_done(first_i, "simul_first");
        if (first_i) i_req = 1'b0; else d_req = 1'b0;
        @(negedge clk);
        chk("simul_idle_gap", {62'h0, i_grant, d_grant}, 64'd0);
        @(negedge clk);
        chk("simul_second_grant", {62'h0, i_grant, d_grant}, first_i ? 64'd1 : 64'd2);
        chk("simul_second_addr", {48'h0, mem_addr}, first_i ? 64'h2000 : 64'h3000);
        wait_done(!first_i, "simul_second");
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);

        // Reset after the third returned word of an icache fill.
        push_fill(0, 16'h7014, 16'h8FEF, 6, 3);
        i_req = 1'b1; i_addr = 16'h7014;
        n = 0;
        while (!(fill_valid === 1'b1 && fill_word == 3'd2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("reset_fill_timeout", 64'd0, 64'd1);
        rst = 1'b0; i_req = 1'b0;
        @(negedge clk);
        chk("midfill_reset_outputs", {6'h0, i_grant, d_grant, fill_data, fill_word, fill_valid,
            i_done, d_done, mem_addr, mem_data_in, mem_en, mem_wr}, 64'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        chk("reset_queues_drained", 64'(fill_q.size() + addr_q.size()), 64'd0);

        // Icache request rising mid-DFILL waits until d_done.
        push_fill(1, 16'h5008, 16'hAFFF, 8, 8);
        push_fill(0, 16'h6000, 16'h9FFF, 8, 8);
        d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h5008;
        repeat (3) @(negedge clk);
        i_req = 1'b1; i_addr = 16'h6000;
        @(negedge clk);
        chk("midfill_no_preempt", {62'h0, i_grant, d_grant}, 64'd1);
        wait_done(1'b0, "dfill_5000");
        d_req = 1'b0;
        wait_done(1'b1, "ifill_6000");
        i_req = 1'b0;
        repeat (3) @(negedge clk);

        chk("final_queues_empty", 64'(fill_q.size() + addr_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_fill_sequencer.md
Name: mem_fill_sequencer

Overview:
- Sits between the instruction cache, the data cache and the shared single-port memory4c.
- Arbitrates icache miss fills, dcache miss fills and dcache write-through stores onto the memory.
- Sequences each miss as an 8-word block fill using pipelined reads, and returns the words to the owning cache, indexed by word number.
- Replaces purely combinational sharing with a state machine, so a fill is never interrupted by the other requester.

Parameters:
- ADDR_W, 16, byte address width.
- DATA_W, 16, word width; one word is 2 bytes.
- WORDS, 8, words per cache block; block size is 16 bytes, so the block offset is addr[3:0].

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-low reset.
- i_req  in  1  icache miss request; level-held until i_done.
- i_addr  in  16  icache miss address.
- d_req  in  1  dcache request (fill or store); level-held until d_done.
- d_wr  in  1  1 = store (write-through), 0 = miss fill; valid while d_req=1.
- d_addr  in  16  dcache address.
- d_wdata  in  16  store data.
- i_grant  out  1  icache transaction in progress.
- d_grant  out  1  dcache transaction in progress.
- fill_data  out  16  returned word.
- fill_word  out  3  word index within the block.
- fill_valid  out  1  fill_data/fill_word valid this cycle.
- i_done  out  1  one-cycle pulse: icache fill complete.
- d_done  out  1  one-cycle pulse: dcache fill or store complete.
- mem_addr  out  16  address to memory4c.
- mem_data_in  out  16  write data to memory4c.
- mem_en  out  1  memory enable.
- mem_wr  out  1  memory write.
- mem_rdata  in  16  memory4c data_out.
- mem_valid  in  1  memory4c data_valid.

Behaviour:
- Reset:
  - Evaluated on the clk edge when rst=0.
  - State goes to IDLE; issue and receive counters go to 0.
  - All outputs are 0.
  - Reset mid-fill abandons the fill with no done pulse. Late mem_valid pulses are ignored because fill_valid is gated by state.
- States: IDLE, IFILL, DFILL, DWRITE.
- IDLE transitions, decided in a single cycle:
  - i_req=1 goes to IFILL (icache has fixed priority).
  - Otherwise d_req & ~d_wr goes to DFILL.
  - Otherwise d_req & d_wr goes to DWRITE.
  - Requests are not sampled in any other state.
- IFILL / DFILL:
  - Block base = {addr[15:4], 4'b0}, latched from the winning requester on entry.
  - The issue counter (0..8) drives mem_en=1, mem_wr=0 and mem_addr = base + 2*issue_cnt for 8 consecutive cycles, starting the cycle after entry. mem_en=0 once issue_cnt=8.
  - Each mem_valid drives fill_valid=1, fill_data=mem_rdata and fill_word=recv_cnt, then recv_cnt increments.
  - The cycle in which the 8th word returns (recv_cnt=7 & mem_valid) pulses i_done or d_done; the next state is IDLE.
  - Fill latency = 1 + 8 + memory latency - 1 cycles from grant.
  - Words always return in order 0..7. There is no critical-word-first.
- DWRITE:
  - Lasts one cycle: mem_en=1, mem_wr=1, mem_addr=d_addr, mem_data_in=d_wdata.
  - d_done pulses that cycle; the next state is IDLE.
  - Entered only from IDLE, so no reads are in flight.
- Grants:
  - i_grant=1 in IFILL; d_grant=1 in DFILL and DWRITE. Grants are combinational from state.
- Request handshake:
  - A requester drops req in the cycle after its done pulse.
  - IDLE re-arbitrates on that cycle, so back-to-back transactions have 1 idle cycle between them.
- Simultaneous i_req and d_req: icache wins. The dcache waits, with d_req held, and is served on the next IDLE.
- mem_valid while in IDLE or DWRITE is ignored.
- Address arithmetic is 16-bit. The base is block-aligned, so base+14 never wraps a block.

Optional Feature:
- Macro: MEM_SEQ_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_owner register, reset to 0 (icache).
  - When i_req and d_req are both pending in IDLE, the requester that was not served last wins.
  - DWRITE counts as a dcache service.
- Undefined: fixed icache priority as described in Behaviour. last_owner does not exist.

Decomposition:
- Package mem_seq_pkg:
  - State enum (IDLE, IFILL, DFILL, DWRITE).
  - WORD_BYTES=2, BLOCK_WORDS=8, BLOCK_OFF_BITS=4.
- Sub-module mem_fill_counter:
  - A 4-bit issue counter and a 3-bit receive counter, with clear and step inputs.
  - Outputs issue_done and last_word.
  - Instantiated once.

Test Plan:
- i_req=1, i_addr=16'h1236:
  - mem_addr steps 16'h1230..16'h123E over 8 cycles.
  - fill_word returns 0..7 with memory contents.
  - i_done pulses with word 7.
- d_req=1, d_wr=1, d_addr=16'h0040, d_wdata=16'hBEEF:
  - One cycle with mem_en=1, mem_wr=1 and d_done=1.
  - A later fill of 16'h0040 returns word 0 = 16'hBEEF.
- i_req and d_req (fill at 16'h2000) asserted in the same cycle:
  - Icache fill completes first, then 1 IDLE cycle, then DFILL issues 16'h2000.
  - d_req held throughout, with no dropped words.
- Same as above with MEM_SEQ_ROUND_ROBIN_EN and last_owner=icache: dcache is served first.
- rst=0 after the 3rd returned word of an IFILL:
  - The next cycle has all outputs 0.
  - Remaining mem_valid pulses produce no fill_valid.
  - No i_done.
- d_req fill in progress and i_req rises mid-fill: DFILL is not interrupted; the icache is granted only after d_done.
